// File: rtl/wb_cla_responder.sv
// Wishbone classic slave that runs a chunked carry-propagate add on bus-loaded operands.
// Optional macro CLA_RESP_IRQ_EN adds the done IRQ pulse and the CTRL bit2 IRQ mask.
module wb_cla_responder #(
  parameter int          WIDTH    = 4,
  parameter int          CHUNK    = 1,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [WIDTH:0]   io_out,
  output logic [WIDTH:0]   io_oeb,
  output logic             user_irq
);

  localparam int NSL   = WIDTH / CHUNK;
  localparam int CNT_W = $clog2(NSL + 1);
  localparam logic [WIDTH-1:0] SMASK = WIDTH'((64'd1 << CHUNK) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state_q, state_d;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] wa_q, wa_d, wb_q, wb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   io_out_q, io_out_d;
`ifdef CLA_RESP_IRQ_EN
  logic             irq_mask_q, irq_mask_d;
  logic             irq_q, irq_d;
`endif

  logic             hit, req, wr, rd, go, go_acc, last;
  logic [1:0]       reg_sel;
  logic [31:0]      bmask, rdata;
  logic [5:0]       base;
  logic [WIDTH-1:0] wa_sh, wb_sh, sum_new;
  logic [CHUNK:0]   slice_sum;
  logic             unused_adr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [31:0] msk);
    return (old & ~msk) | (nw & msk);
  endfunction

  // Ack low is part of the request so every access takes at least two cycles.
  assign hit     = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign req     = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
  assign wr      = req & wbs_we_i;
  assign rd      = req & ~wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];
  assign bmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign go      = wr & (reg_sel == 2'd0) & wbs_sel_i[0] & wbs_dat_i[0];
  assign go_acc  = go & (state_q != S_BUSY);
  assign last    = (state_q == S_BUSY) & (cnt_q == CNT_W'(NSL - 1));
  assign unused_adr = ^wbs_adr_i[1:0];

  // Current slice of the working operands plus the running carry.
  assign base      = 6'(cnt_q) * 6'(CHUNK);
  assign wa_sh     = wa_q >> base;
  assign wb_sh     = wb_q >> base;
  assign slice_sum = {1'b0, wa_sh[CHUNK-1:0]} + {1'b0, wb_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign sum_new   = (sum_q & ~(SMASK << base)) | (WIDTH'(slice_sum[CHUNK-1:0]) << base);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (go_acc) state_d = S_BUSY;
      S_BUSY:         if (last)   state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: begin
        rdata[0] = cin_q;
`ifdef CLA_RESP_IRQ_EN
        rdata[2] = irq_mask_q;
`endif
      end
      2'd1: rdata = 32'(opa_q);
      2'd2: rdata = 32'(opb_q);
      default: begin
        rdata[WIDTH-1:0] = sum_q;
        rdata[WIDTH]     = cout_q;
        rdata[30]        = (state_q == S_BUSY);
        rdata[31]        = done_q;
      end
    endcase
  end

  always_comb begin
    ack_d    = req;
    dat_d    = rd ? rdata : '0;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cin_d    = cin_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    io_out_d = io_out_q;
`ifdef CLA_RESP_IRQ_EN
    irq_mask_d = irq_mask_q;
    irq_d      = 1'b0;
`endif
    if (wr) begin
      case (reg_sel)
        2'd0: if (wbs_sel_i[0]) begin
          cin_d = wbs_dat_i[1];
`ifdef CLA_RESP_IRQ_EN
          irq_mask_d = wbs_dat_i[2];
`endif
        end
        2'd1:    opa_d = WIDTH'(merge(32'(opa_q), wbs_dat_i, bmask));
        2'd2:    opb_d = WIDTH'(merge(32'(opb_q), wbs_dat_i, bmask));
        default: ;
      endcase
    end
    // The add uses a private copy, so bus writes during BUSY cannot disturb it.
    if (go_acc) begin
      wa_d    = opa_q;
      wb_d    = opb_q;
      carry_d = cin_d;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
    if (state_q == S_BUSY) begin
      carry_d = slice_sum[CHUNK];
      sum_d   = sum_new;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last) begin
        cout_d   = slice_sum[CHUNK];
        done_d   = 1'b1;
        io_out_d = {slice_sum[CHUNK], sum_new};
`ifdef CLA_RESP_IRQ_EN
        irq_d    = ~irq_mask_q;
`endif
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      wa_q     <= '0;
      wb_q     <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      io_out_q <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cin_q    <= cin_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      io_out_q <= io_out_d;
    end
  end

`ifdef CLA_RESP_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end
  assign user_irq = irq_q;
`else
  assign user_irq = 1'b0;
`endif

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = io_out_q;
  assign io_oeb    = '0;

endmodule

// File: tb/tb_wb_cla_responder.sv
// Scoreboard bench for wb_cla_responder: bus driver queues expectations, an ack monitor checks them.
module tb_wb_cla_responder;
  localparam int          W = 4;
  localparam logic [31:0] B = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   dat_i = '0, adr = '0;
  logic          ack;
  logic [31:0]   dat_o;
  logic [W:0]    io_out, io_oeb;
  logic          user_irq;

  always #5 clk = ~clk;

  wb_cla_responder #(.WIDTH(W), .CHUNK(1), .BASE_ADR(B)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .io_out(io_out), .io_oeb(io_oeb), .user_irq(user_irq)
  );

  typedef struct {
    bit          rd;
    logic [31:0] exp;
    logic [31:0] msk;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t ent;
  int   nchk = 0, nfail = 0, irq_cnt = 0, exp_irq;
  logic ack_prev = 1'b0, irq_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ack pops one queued access; reads are compared under a mask.
  always @(negedge clk) begin
    if (user_irq) begin
      irq_cnt++;
      chk("irq_one_cycle", {31'b0, irq_prev}, 32'h0);
    end
    if (ack) begin
      chk("ack_back_to_back", {31'b0, ack_prev}, 32'h0);
      if (sbq.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL spurious_ack: got ack with no access pending, expected none");
      end else begin
        ent = sbq.pop_front();
        if (ent.rd) chk(ent.name, dat_o & ent.msk, ent.exp);
      end
    end
    ack_prev = ack;
    irq_prev = user_irq;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit w, input logic [7:0] off, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, input logic [31:0] msk, input string nm);
    bit got = 0;
    exp_t e;
    e.rd = !w; e.exp = exp; e.msk = msk; e.name = nm;
    sbq.push_back(e);
    stb = 1; cyc = 1; we = w; adr = B + 32'(off); dat_i = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1;
    end
    stb = 0; cyc = 0; we = 0;
    if (!got) begin
      nchk++; nfail++;
      $display("FAIL %s_timeout: got no ack in 8 cycles, expected ack", nm);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
    bus(1, off, d, s, '0, '0, "write");
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm,
                    input logic [31:0] msk = 32'hFFFF_FFFF);
    bus(0, off, '0, 4'hF, exp, msk, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    repeat (2) @(posedge clk);
    #1 wb_rst_i = 0;

    rd(8'h0, 32'h0, "rst_ctrl");
    rd(8'h4, 32'h0, "rst_opa");
    rd(8'h8, 32'h0, "rst_opb");
    rd(8'hC, 32'h0, "rst_result");
    chk("rst_io_out", 32'(io_out), 32'h0);
    chk("io_oeb", 32'(io_oeb), 32'h0);

    // 9 + 8 + 1 = 18 -> sum 2, cout 1
    wr(8'h4, 32'd9);
    wr(8'h8, 32'd8);
    wr(8'h0, 32'h3);
    rd(8'hC, 32'h4000_0000, "basic_busy1", 32'hC000_0000);
    rd(8'hC, 32'h4000_0000, "basic_busy2", 32'hC000_0000);
    rd(8'hC, 32'h8000_0012, "basic_result");
    rd(8'h0, 32'h1, "basic_ctrl");
    rd(8'h4, 32'h9, "basic_opa");
    chk("basic_io_out", 32'(io_out), 32'h12);

    // 0xF + 0x1 wraps to 0 with carry out
    wr(8'h4, 32'hF);
    wr(8'h8, 32'h1);
    wr(8'h0, 32'h1);
    idle(6);
    rd(8'hC, 32'h8000_0010, "wrap_result");
    chk("wrap_io_out", 32'(io_out), 32'h10);

    // In-flight add keeps 3+4+0; OPA/CIN writes and re-GO while busy do not disturb it
    wr(8'h4, 32'h3);
    wr(8'h8, 32'h4);
    wr(8'h0, 32'h1);
    wr(8'h4, 32'h0);
    wr(8'h0, 32'h3);
    idle(4);
    rd(8'hC, 32'h8000_0007, "busy_result");
    rd(8'h4, 32'h0, "busy_opa_updated");
    rd(8'h0, 32'h1, "busy_cin_updated");
    chk("busy_io_out", 32'(io_out), 32'h07);

    // Byte lanes
    wr(8'h4, 32'hA);
    wr(8'h4, 32'h5, 4'b0000);
    rd(8'h4, 32'hA, "sel_none");
    wr(8'h4, 32'hFFFF_FFFF, 4'b0010);
    rd(8'h4, 32'hA, "sel_lane1");
    wr(8'h4, 32'hFFFF_FF03, 4'b0001);
    rd(8'h4, 32'h3, "sel_lane0");
    wr(8'hC, 32'hFFFF_FFFF);
    rd(8'hC, 32'h8000_0007, "result_ro");

    // Outside the window: no ack
    got = 0;
    stb = 1; cyc = 1; we = 0; adr = B + 32'h10; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1;
    end
    stb = 0; cyc = 0;
    chk("miss_no_ack", {31'b0, got}, 32'h0);

    // Reset in the middle of BUSY
    wr(8'h4, 32'h5);
    wr(8'h8, 32'h6);
    wr(8'h0, 32'h1);
    @(posedge clk); #1 wb_rst_i = 1;
    @(posedge clk); #1 wb_rst_i = 0;
    chk("midrst_io_out", 32'(io_out), 32'h0);
    rd(8'hC, 32'h0, "midrst_result");
    rd(8'h4, 32'h0, "midrst_opa");
    rd(8'h8, 32'h0, "midrst_opb");
    rd(8'h0, 32'h0, "midrst_ctrl");

    // Fresh GO after reset: 6 + 7 = 13
    wr(8'h4, 32'h6);
    wr(8'h8, 32'h7);
    wr(8'h0, 32'h1);
    idle(6);
    rd(8'hC, 32'h8000_000D, "fresh_result");
    chk("fresh_io_out", 32'(io_out), 32'h0D);

    // GO with IRQ mask bit set: completes without a pulse
    wr(8'h0, 32'h5);
    idle(6);
    rd(8'hC, 32'h8000_000D, "masked_result");
`ifdef CLA_RESP_IRQ_EN
    rd(8'h0, 32'h4, "ctrl_mask");
    exp_irq = 4;
`else
    rd(8'h0, 32'h0, "ctrl_mask");
    exp_irq = 0;
`endif
    idle(2);
    chk("irq_count", 32'(irq_cnt), 32'(exp_irq));
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
